output_spi_scheduler: RTL

Frame scheduler in front of `outputSPI`. It shares the single nibble-serial output link between two byte-stream requesters: ciphertext (src 0) and status/log (src 1). It grants one requester per frame with round-robin arbitration and prepends a header byte. It then drives `outputSPI`'s `en`/`in` pair, holding each byte for exactly BYTE_CYCLES clocks while `outputSPI` shifts it out as two nibbles.

---
 rtl/output_spi_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/output_spi_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/output_spi_pkg.sv
// Shared types and helpers for the output SPI frame scheduler.
// Covers the frame FSM states, the header magic nibble and the header byte format.
package output_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEND,
        S_STALL,
        S_GAP
    } state_e;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    // Header byte: magic nibble, three reserved zero bits, then the source index.
    function automatic logic [7:0] hdr_byte(input logic src);
        return {HDR_MAGIC, 3'b000, src};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
// The scheduler registers the result.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       pri,
    output logic       gnt_idx,
    output logic       any
);

    always_comb begin
        any     = |req;
        gnt_idx = 1'b0;
        if (req[0] && req[1]) begin
            gnt_idx = pri;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/output_spi_scheduler.sv
// Frame scheduler sharing one nibble-serial output link between two byte streams.
// Each frame is a header byte plus payload, and each byte is held for BYTE_CYCLES clocks.
module output_spi_scheduler
    import output_spi_pkg::*;
#(
    parameter int BYTE_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_LEN     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic [7:0] data0,
    input  logic       last0,
    input  logic       valid1,
    input  logic [7:0] data1,
    input  logic       last1,
    output logic       ready0,
    output logic       ready1,
    output logic       spi_en,
    output logic [7:0] spi_in,
    output logic       busy,
    output logic       grant,
    output logic       err_trunc
);

    localparam int SLOT_W = $clog2(BYTE_CYCLES);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BYTE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        LEN_MAX   = 8'(MAX_LEN);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        spi_in_q, spi_in_d;
    logic              grant_q, grant_d;
    logic              pri_q, pri_d;
    logic              last_q, last_d;

    logic       arb_gnt, arb_any;
    logic       valid_g, last_g;
    logic [7:0] data_g;
    logic [7:0] len_inc;
    logic       hit_max;
    logic       fetch;

    rr_arbiter2 u_arb (
        .req     ({valid1, valid0}),
        .pri     (pri_q),
        .gnt_idx (arb_gnt),
        .any     (arb_any)
    );

    assign valid_g = grant_q ? valid1 : valid0;
    assign data_g  = grant_q ? data1  : data0;
    assign last_g  = grant_q ? last1  : last0;
    assign len_inc = len_q + 8'd1;
    assign hit_max = (len_inc == LEN_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            gap_q    <= '0;
            len_q    <= 8'd0;
            spi_in_q <= 8'h00;
            grant_q  <= 1'b0;
            pri_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            gap_q    <= gap_d;
            len_q    <= len_d;
            spi_in_q <= spi_in_d;
            grant_q  <= grant_d;
            pri_q    <= pri_d;
            last_q   <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        gap_d    = gap_q;
        len_d    = len_q;
        spi_in_d = spi_in_q;
        grant_d  = grant_q;
        pri_d    = pri_q;
        last_d   = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    grant_d  = arb_gnt;
                    spi_in_d = hdr_byte(arb_gnt);
                    slot_d   = '0;
                    len_d    = 8'd0;
                    last_d   = 1'b0;
                    state_d  = S_HDR;
                end
            end
            S_HDR, S_SEND: begin
                if (slot_q != SLOT_LAST) begin
                    slot_d = slot_q + SLOT_W'(1);
                end else if (state_q == S_SEND && last_q) begin
                    // Frame done: hand priority to the other source.
                    slot_d  = '0;
                    gap_d   = '0;
                    pri_d   = ~grant_q;
                    state_d = S_GAP;
                end else if (valid_g) begin
                    spi_in_d = data_g;
                    len_d    = len_inc;
                    last_d   = last_g | hit_max;
                    slot_d   = '0;
                    state_d  = S_SEND;
                end else begin
                    slot_d  = '0;
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (valid_g) begin
                    spi_in_d = data_g;
                    len_d    = len_inc;
                    last_d   = last_g | hit_max;
                    slot_d   = '0;
                    state_d  = S_SEND;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is a pure state decode so it never loops back through valid.
    always_comb begin
        fetch = ((state_q == S_HDR) && (slot_q == SLOT_LAST))
              || ((state_q == S_SEND) && (slot_q == SLOT_LAST) && !last_q)
              || (state_q == S_STALL);
        ready0    = fetch && !grant_q;
        ready1    = fetch && grant_q;
        spi_en    = (state_q == S_HDR) || (state_q == S_SEND);
        busy      = (state_q != S_IDLE);
        err_trunc = fetch && valid_g && hit_max && !last_g;
        spi_in    = spi_in_q;
        grant     = grant_q;
    end

endmodule
